// File: rtl/phase_scheduler_pkg.sv
// Shared phase codes, scheduler states, defaults and the round-robin picker.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package phase_scheduler_pkg;

    typedef logic [1:0] phase_t;

    localparam phase_t PH_SS_STRAIGHT = 2'd0;
    localparam phase_t PH_SS_TURN     = 2'd1;
    localparam phase_t PH_CS_STRAIGHT = 2'd2;
    localparam phase_t PH_CS_TURN     = 2'd3;

    localparam int DEFAULT_SEC_TICKS = 1000;
    localparam int DEFAULT_MIN_GREEN = 10;

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_SELECT  = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_SERVING = 2'd3
    } sched_state_t;

    // Search last+1, last+2, last+3, last (mod 4) for the first pending
    // phase; fall back to the straight-street straight recall phase.
    function automatic phase_t rr_pick(input logic [3:0] dem, input phase_t last);
        phase_t pick;
        phase_t idx;
        logic   found;
        pick  = PH_SS_STRAIGHT;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + i[1:0];
            if (!found && dem[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/phase_scheduler_if.sv
// Bundle of intersection inputs and the scheduler/sequencer grant handshake.
// Latency: n/a (wiring only).
// Backpressure: none; phase_done is a pulse, the sequencer owns pacing.
interface phase_scheduler_if;
    import phase_scheduler_pkg::*;

    logic   straight_street_pedestrian_button;
    logic   cross_street_pedestrian_button;
    logic   straight_street_straight_lane_car_sensor;
    logic   straight_street_turn_lane_car_sensor;
    logic   cross_street_straight_lane_car_sensor;
    logic   cross_street_turn_lane_car_sensor;
    logic   phase_done;

    phase_t     phase;
    logic       phase_start;
    logic       straight_street_ped_enable;
    logic       cross_street_ped_enable;
    logic       early_end;
    logic [3:0] demand;

    // Scheduler side
    modport master (
        input  straight_street_pedestrian_button,
        input  cross_street_pedestrian_button,
        input  straight_street_straight_lane_car_sensor,
        input  straight_street_turn_lane_car_sensor,
        input  cross_street_straight_lane_car_sensor,
        input  cross_street_turn_lane_car_sensor,
        input  phase_done,
        output phase,
        output phase_start,
        output straight_street_ped_enable,
        output cross_street_ped_enable,
        output early_end,
        output demand
    );

    // Sensor / sequencer side
    modport slave (
        output straight_street_pedestrian_button,
        output cross_street_pedestrian_button,
        output straight_street_straight_lane_car_sensor,
        output straight_street_turn_lane_car_sensor,
        output cross_street_straight_lane_car_sensor,
        output cross_street_turn_lane_car_sensor,
        output phase_done,
        input  phase,
        input  phase_start,
        input  straight_street_ped_enable,
        input  cross_street_ped_enable,
        input  early_end,
        input  demand
    );

endinterface

// File: rtl/phase_scheduler_input_sync.sv
// Two-flop synchronizer for asynchronous level inputs, WIDTH bits wide.
// Latency: 2 clk cycles from input change to o_sync.
// Backpressure: none; free-running.
module input_sync #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Metastability filter: capture then re-register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/phase_scheduler.sv
// Demand-driven round-robin phase arbiter feeding the light-timing sequencer.
// Latency: input->demand 3 cycles; phase_done->phase_start 2 cycles.
// Backpressure: a new grant is issued only after the sequencer pulses phase_done.
module phase_scheduler
    import phase_scheduler_pkg::*;
#(
    parameter int SEC_TICKS = DEFAULT_SEC_TICKS,
    parameter int MIN_GREEN = DEFAULT_MIN_GREEN
) (
    input  logic              clk,
    input  logic              rst,
    phase_scheduler_if.master sched
);

    localparam int PW = (SEC_TICKS > 1) ? $clog2(SEC_TICKS) : 1;

    // Sync bit map: [3:0] car sensors by phase, [4] SS ped, [5] CS ped
    logic [5:0]   w_raw;
    logic [5:0]   w_sync;

    sched_state_t r_state;
    sched_state_t w_state_nxt;
    logic         w_phase_start;
    logic         w_serving;

    phase_t       r_phase;
    phase_t       r_last;
    phase_t       w_pick;
    logic [3:0]   w_phase_oh;
    logic [3:0]   w_mask;
    logic [3:0]   w_clr;

    logic [3:0]   r_vdem;
    logic         r_pdem_ss;
    logic         r_pdem_cs;
    logic [3:0]   w_demand;

    logic         r_ss_ped_en;
    logic         r_cs_ped_en;
    logic [PW-1:0] r_presc;
    logic [7:0]   r_green_secs;
    logic         r_early_end;

    assign w_raw = {sched.cross_street_pedestrian_button,
                    sched.straight_street_pedestrian_button,
                    sched.cross_street_turn_lane_car_sensor,
                    sched.cross_street_straight_lane_car_sensor,
                    sched.straight_street_turn_lane_car_sensor,
                    sched.straight_street_straight_lane_car_sensor};

    input_sync #(.WIDTH(6)) u_input_sync (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_async (w_raw),
        .o_sync  (w_sync)
    );

    // Scheduler state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RESET;
        else     r_state <= w_state_nxt;
    end

    // Next-state and grant pulse decode
    always_comb begin
        w_state_nxt   = r_state;
        w_phase_start = 1'b0;
        case (r_state)
            ST_RESET:   w_state_nxt = ST_SELECT;
            ST_SELECT:  w_state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                w_phase_start = 1'b1;
                w_state_nxt   = ST_SERVING;
            end
            ST_SERVING: if (sched.phase_done) w_state_nxt = ST_SELECT;
            default:    w_state_nxt = ST_RESET;
        endcase
    end

    assign w_serving  = (r_state == ST_SERVING);
    assign w_phase_oh = 4'b0001 << r_phase;
    // Own sensor/button cannot re-arm while its green is running
    assign w_mask     = w_serving     ? w_phase_oh : 4'b0000;
    // Grant consumes the demand; clear dominates a simultaneous set
    assign w_clr      = w_phase_start ? w_phase_oh : 4'b0000;
    assign w_demand   = r_vdem | {1'b0, r_pdem_cs, 1'b0, r_pdem_ss};
    assign w_pick     = rr_pick(w_demand, r_last);

    // Demand latch: set on synchronized level, cleared by the grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vdem    <= '0;
            r_pdem_ss <= 1'b0;
            r_pdem_cs <= 1'b0;
        end else begin
            r_vdem    <= (r_vdem | (w_sync[3:0] & ~w_mask)) & ~w_clr;
            r_pdem_ss <= (r_pdem_ss | (w_sync[4] & ~w_mask[0])) & ~w_clr[0];
            r_pdem_cs <= (r_pdem_cs | (w_sync[5] & ~w_mask[2])) & ~w_clr[2];
        end
    end

    // Grant register; ped enables follow the ped demand seen at grant time
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase     <= PH_SS_STRAIGHT;
            r_last      <= PH_CS_TURN;
            r_ss_ped_en <= 1'b0;
            r_cs_ped_en <= 1'b0;
        end else if (r_state == ST_SELECT) begin
            r_phase     <= w_pick;
            r_last      <= w_pick;
            r_ss_ped_en <= (w_pick == PH_SS_STRAIGHT) && r_pdem_ss;
            r_cs_ped_en <= (w_pick == PH_CS_STRAIGHT) && r_pdem_cs;
        end else if (w_serving && sched.phase_done) begin
            r_ss_ped_en <= 1'b0;
            r_cs_ped_en <= 1'b0;
        end
    end

    // Green timer: seconds prescaler and saturating elapsed-seconds count
    always_ff @(posedge clk) begin
        if (rst || (r_state == ST_ISSUE)) begin
            r_presc      <= '0;
            r_green_secs <= '0;
        end else if (w_serving) begin
            if (r_presc == PW'(SEC_TICKS - 1)) begin
                r_presc <= '0;
                if (r_green_secs != 8'hFF) r_green_secs <= r_green_secs + 8'd1;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    // Early-termination request once minimum green has elapsed and others wait
    always_ff @(posedge clk) begin
        if (rst) r_early_end <= 1'b0;
        else     r_early_end <= w_serving && (r_green_secs >= 8'(MIN_GREEN)) &&
                                (|(w_demand & ~w_phase_oh));
    end

    assign sched.phase                      = r_phase;
    assign sched.phase_start                = w_phase_start;
    assign sched.straight_street_ped_enable = r_ss_ped_en;
    assign sched.cross_street_ped_enable    = r_cs_ped_en;
    assign sched.early_end                  = r_early_end;
    assign sched.demand                     = w_demand;

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed bench for phase_scheduler with 10-tick seconds.
// Latency: n/a.
// Backpressure: n/a; bench plays the sequencer by pulsing phase_done.
module tb_phase_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   starts;

    always #5 clk = ~clk;

    phase_scheduler_if sched();

    phase_scheduler #(.SEC_TICKS(10), .MIN_GREEN(10)) dut (
        .clk   (clk),
        .rst   (rst),
        .sched (sched)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Sequencer finishes the current phase; returns just after the ISSUE edge
    task automatic grant_next();
        sched.phase_done = 1'b1;
        tick();
        sched.phase_done = 1'b0;
        tick();
    endtask

    task automatic set_all(input logic v);
        sched.straight_street_pedestrian_button        = v;
        sched.cross_street_pedestrian_button           = v;
        sched.straight_street_straight_lane_car_sensor = v;
        sched.straight_street_turn_lane_car_sensor     = v;
        sched.cross_street_straight_lane_car_sensor    = v;
        sched.cross_street_turn_lane_car_sensor        = v;
    endtask

    initial begin
        set_all(1'b0);
        sched.phase_done = 1'b0;

        // Reset state
        ticks(3);
        chk("rst_phase",       8'(sched.phase), 8'd0);
        chk("rst_phase_start", 8'(sched.phase_start), 8'd0);
        chk("rst_ss_ped",      8'(sched.straight_street_ped_enable), 8'd0);
        chk("rst_cs_ped",      8'(sched.cross_street_ped_enable), 8'd0);
        chk("rst_early_end",   8'(sched.early_end), 8'd0);
        chk("rst_demand",      8'(sched.demand), 8'd0);

        // Release: SELECT then ISSUE with recall phase 0
        rst = 1'b0;
        tick();
        chk("rel_select_no_start", 8'(sched.phase_start), 8'd0);
        tick();
        chk("rel_issue_start", 8'(sched.phase_start), 8'd1);
        chk("rel_issue_phase", 8'(sched.phase), 8'd0);
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sched.phase_start === 1'b1) starts++;
        end
        chk("idle_no_regrant", 8'(starts), 8'd0);
        chk("idle_ss_ped",     8'(sched.straight_street_ped_enable), 8'd0);
        chk("idle_early_end",  8'(sched.early_end), 8'd0);

        // One-cycle CS-turn pulse: latched after 3 edges, phases 1/2 skipped
        sched.cross_street_turn_lane_car_sensor = 1'b1;
        tick();
        sched.cross_street_turn_lane_car_sensor = 1'b0;
        tick();
        chk("lat_demand_2cyc", 8'(sched.demand), 8'h0);
        tick();
        chk("lat_demand_3cyc", 8'(sched.demand), 8'h8);
        ticks(20);
        chk("short_green_no_early", 8'(sched.early_end), 8'd0);
        grant_next();
        chk("skip_start", 8'(sched.phase_start), 8'd1);
        chk("skip_phase", 8'(sched.phase), 8'd3);
        tick();
        chk("grant_clears_demand", 8'(sched.demand), 8'h0);

        // Nothing pending -> recall phase 0
        grant_next();
        chk("recall_phase", 8'(sched.phase), 8'd0);

        // early_end: CS straight held from second 2, rises 1 cycle after secs=10
        ticks(20);
        sched.cross_street_straight_lane_car_sensor = 1'b1;
        ticks(80);
        chk("ee_demand",    8'(sched.demand), 8'h4);
        chk("ee_secs9",     8'(sched.early_end), 8'd0);
        tick();
        chk("ee_secs10",    8'(sched.early_end), 8'd0);
        tick();
        chk("ee_rise",      8'(sched.early_end), 8'd1);
        sched.phase_done = 1'b1;
        tick();
        sched.phase_done = 1'b0;
        chk("ee_hold_done", 8'(sched.early_end), 8'd1);
        tick();
        chk("ee_fall",      8'(sched.early_end), 8'd0);
        chk("ee_next_phase", 8'(sched.phase), 8'd2);
        chk("ee_next_cs_ped", 8'(sched.cross_street_ped_enable), 8'd0);
        sched.cross_street_straight_lane_car_sensor = 1'b0;

        // Queue phase 1 while phase 2 serves
        sched.straight_street_turn_lane_car_sensor = 1'b1;
        tick();
        sched.straight_street_turn_lane_car_sensor = 1'b0;
        ticks(2);
        chk("p1_demand", 8'(sched.demand), 8'h2);
        grant_next();
        chk("p1_phase", 8'(sched.phase), 8'd1);

        // CS ped pressed during phase 1 -> phase 2 with ped enable
        sched.cross_street_pedestrian_button = 1'b1;
        tick();
        sched.cross_street_pedestrian_button = 1'b0;
        ticks(2);
        chk("csped_demand", 8'(sched.demand), 8'h4);
        grant_next();
        chk("csped_phase",  8'(sched.phase), 8'd2);
        chk("csped_en_issue", 8'(sched.cross_street_ped_enable), 8'd1);
        chk("csped_ss_off", 8'(sched.straight_street_ped_enable), 8'd0);
        ticks(20);
        chk("csped_en_hold", 8'(sched.cross_street_ped_enable), 8'd1);
        sched.phase_done = 1'b1;
        tick();
        sched.phase_done = 1'b0;
        chk("csped_en_drop", 8'(sched.cross_street_ped_enable), 8'd0);
        tick();
        chk("csped_recall", 8'(sched.phase), 8'd0);

        // SS ped during phase 0 is masked
        tick();
        sched.straight_street_pedestrian_button = 1'b1;
        ticks(4);
        sched.straight_street_pedestrian_button = 1'b0;
        ticks(3);
        chk("ssped_masked_demand", 8'(sched.demand), 8'h0);
        chk("ssped_masked_en",     8'(sched.straight_street_ped_enable), 8'd0);

        // All inputs high: 1, 2, 3, 0 in turn
        set_all(1'b1);
        ticks(4);
        chk("all_demand", 8'(sched.demand), 8'hE);
        ticks(5);
        grant_next();
        chk("all_start1", 8'(sched.phase_start), 8'd1);
        chk("all_phase1", 8'(sched.phase), 8'd1);
        ticks(5);
        grant_next();
        chk("all_phase2", 8'(sched.phase), 8'd2);
        chk("all_cs_ped", 8'(sched.cross_street_ped_enable), 8'd1);
        ticks(5);
        grant_next();
        chk("all_phase3", 8'(sched.phase), 8'd3);
        ticks(5);
        grant_next();
        chk("all_phase0", 8'(sched.phase), 8'd0);
        chk("all_ss_ped", 8'(sched.straight_street_ped_enable), 8'd1);

        // Build demand 1011 during phase 2, then reset mid-grant
        set_all(1'b0);
        ticks(3);
        chk("mr_demand0", 8'(sched.demand), 8'hE);
        grant_next();
        chk("mr_phase1", 8'(sched.phase), 8'd1);
        ticks(3);
        grant_next();
        chk("mr_phase2", 8'(sched.phase), 8'd2);
        sched.straight_street_straight_lane_car_sensor = 1'b1;
        sched.straight_street_turn_lane_car_sensor     = 1'b1;
        tick();
        sched.straight_street_straight_lane_car_sensor = 1'b0;
        sched.straight_street_turn_lane_car_sensor     = 1'b0;
        ticks(2);
        chk("mr_demand1011", 8'(sched.demand), 8'hB);
        chk("mr_cs_ped",     8'(sched.cross_street_ped_enable), 8'd1);
        rst = 1'b1;
        tick();
        chk("mr_phase",       8'(sched.phase), 8'd0);
        chk("mr_demand",      8'(sched.demand), 8'h0);
        chk("mr_cs_ped_off",  8'(sched.cross_street_ped_enable), 8'd0);
        chk("mr_phase_start", 8'(sched.phase_start), 8'd0);
        chk("mr_early_end",   8'(sched.early_end), 8'd0);
        ticks(2);
        rst = 1'b0;
        tick();
        chk("mr_rel_no_start", 8'(sched.phase_start), 8'd0);
        tick();
        chk("mr_rel_start", 8'(sched.phase_start), 8'd1);
        chk("mr_rel_phase", 8'(sched.phase), 8'd0);
        chk("mr_rel_demand", 8'(sched.demand), 8'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
